// File: rtl/sw_debounce.sv
// sw_debounce
// Debounces a bank of N raw board switches. Each bit is synchronized with two
// flops. It then has to disagree with its debounced value for DEB_CYCLES
// consecutive clocks before the debounced value follows it. Every update raises
// a one-cycle change pulse and a mask of the bits that changed on that edge.
// All outputs come straight from flops.
//
// Per-bit timing, with sw_in changing before edge E:
//   E       : sync1 captures the new level
//   E+1     : sync2 captures it; the per-bit counter starts counting from 0
//   E+2..   : the counter increments while sync2 disagrees with sw_stable
//   E+DEB+1 : the counter sits at DEB_CYCLES-1 and the bit qualifies, so
//             sw_stable, sw_change and change_mask all update on this edge
// Counting E itself, that is DEB_CYCLES+2 edges in total.
//
// DEB_CYCLES legal range: 2 .. 2^20-1.

module sw_debounce #(
    parameter int N          = 10,
    parameter int DEB_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw_in,
    output logic [N-1:0] sw_stable,
    output logic         sw_change,
    output logic [N-1:0] change_mask
);

    localparam int            CNT_W = 20;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEB_CYCLES - 1);

    logic [N-1:0]     sync1_q, sync1_d;
    logic [N-1:0]     sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    logic [N-1:0]     stable_q, stable_d;
    logic [N-1:0]     mask_q, mask_d;
    logic             change_q, change_d;

    // Two-stage synchronizer input for the raw asynchronous switches.
    always_comb begin
        sync1_d = sw_in;
        sync2_d = sync1_q;
    end

    // Per-bit qualify counter and debounced-value update. A disagreeing bit
    // counts up to the terminal count. It qualifies on the edge after it
    // reaches that count. Any agreement clears the count, so one bounce back
    // restarts the full window.
    always_comb begin
        stable_d = stable_q;
        mask_d   = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] < CNT_TC) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end else begin
                    stable_d[i] = sync2_q[i];
                    mask_d[i]   = 1'b1;
                end
            end
        end
        change_d = |mask_d;
    end

    // State registers; reset clears every stage, so no partial count survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            mask_q   <= '0;
            change_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            mask_q   <= mask_d;
            change_q <= change_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Registered outputs only: there is no combinational path from sw_in.
    always_comb begin
        sw_stable   = stable_q;
        sw_change   = change_q;
        change_mask = mask_q;
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Testbench for sw_debounce (N = 10, DEB_CYCLES = 4). Expected change pulses
// are queued with the edge number they must appear on. A negedge monitor pops
// each entry and checks the pulse against it.

module tb_sw_debounce;

    localparam int N   = 10;
    localparam int DEB = 4;
    localparam int LAT = DEB + 2;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] sw_in = '0;
    logic [N-1:0] sw_stable;
    logic         sw_change;
    logic [N-1:0] change_mask;

    typedef struct {
        int           cyc;
        logic [N-1:0] st;
        logic [N-1:0] mk;
    } exp_t;

    exp_t         sb[$];
    int           cyc      = 0;
    int           chk_cnt  = 0;
    int           pass_cnt = 0;
    logic [N-1:0] exp_st   = '0;

    sw_debounce #(.N(N), .DEB_CYCLES(DEB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_in       (sw_in),
        .sw_stable   (sw_stable),
        .sw_change   (sw_change),
        .change_mask (change_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Scoreboard monitor: every pulse must match the head of the queue, and
    // outside pulses the mask must be zero and no pulse may be overdue.
    always @(negedge clk) begin
        exp_t e;
        bit   due;
        due = (sb.size() > 0) && (sb[0].cyc <= cyc);
        chk_cnt++;
        if (sw_change) begin
            if (sb.size() == 0) begin
                $display("FAIL pulse_unexpected cyc=%0d stable=%h mask=%h (no pulse expected)",
                         cyc, sw_stable, change_mask);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.cyc || sw_stable !== e.st || change_mask !== e.mk)
                    $display("FAIL pulse cyc=%0d stable=%h mask=%h, expected cyc=%0d stable=%h mask=%h",
                             cyc, sw_stable, change_mask, e.cyc, e.st, e.mk);
                else
                    pass_cnt++;
            end
        end else begin
            if (due || change_mask !== '0) begin
                $display("FAIL idle cyc=%0d change=%b mask=%h, expected pulse_due=%0b mask=000",
                         cyc, sw_change, change_mask, due);
                if (due) void'(sb.pop_front());
            end else begin
                pass_cnt++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle_to(input logic [N-1:0] v);
        if (v != exp_st) sb.push_back('{cyc + LAT, v, v ^ exp_st});
        exp_st = v;
        sw_in  = v;
        tick(LAT + 3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        chk_cnt++;
        if (sw_stable !== '0 || sw_change !== 1'b0 || change_mask !== '0)
            $display("FAIL reset_state stable=%h change=%b mask=%h, expected 000/0/000",
                     sw_stable, sw_change, change_mask);
        else pass_cnt++;
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_clean_step();
        sw_in = 10'h001;
        sb.push_back('{cyc + LAT, 10'h001, 10'h001});
        exp_st = 10'h001;
        tick(LAT - 1);
        chk_cnt++;
        if (sw_stable !== 10'h000) $display("FAIL step_early stable=%h, expected 000", sw_stable);
        else pass_cnt++;
        tick(1);
        chk_cnt++;
        if (sw_stable !== 10'h001 || sw_change !== 1'b1)
            $display("FAIL step_update stable=%h change=%b, expected 001/1", sw_stable, sw_change);
        else pass_cnt++;
        tick(1);
        chk_cnt++;
        if (sw_change !== 1'b0 || sw_stable !== 10'h001)
            $display("FAIL step_one_cycle change=%b stable=%h, expected 0/001", sw_change, sw_stable);
        else pass_cnt++;
        tick(2);
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 4; k++) begin
            sw_in = (k % 2 == 0) ? 10'h008 : 10'h000;
            tick(2);
        end
        sw_in = 10'h008;
        sb.push_back('{cyc + LAT, 10'h008, 10'h008});
        exp_st = 10'h008;
        tick(LAT - 1);
        chk_cnt++;
        if (sw_stable[3] !== 1'b0) $display("FAIL bounce_early stable=%h, expected 000", sw_stable);
        else pass_cnt++;
        tick(1);
        chk_cnt++;
        if (sw_stable !== 10'h008) $display("FAIL bounce_final stable=%h, expected 008", sw_stable);
        else pass_cnt++;
        tick(3);
    endtask

    task automatic test_simultaneous();
        sw_in = 10'h3FF;
        sb.push_back('{cyc + LAT, 10'h3FF, 10'h3FF});
        exp_st = 10'h3FF;
        tick(LAT - 1);
        chk_cnt++;
        if (sw_stable !== 10'h000) $display("FAIL simul_early stable=%h, expected 000", sw_stable);
        else pass_cnt++;
        tick(1);
        chk_cnt++;
        if (sw_stable !== 10'h3FF || change_mask !== 10'h3FF)
            $display("FAIL simul_update stable=%h mask=%h, expected 3ff/3ff", sw_stable, change_mask);
        else pass_cnt++;
        tick(2);
    endtask

    task automatic test_release();
        sw_in = 10'h2FF;
        sb.push_back('{cyc + LAT, 10'h2FF, 10'h100});
        exp_st = 10'h2FF;
        tick(LAT - 1);
        chk_cnt++;
        if (sw_stable !== 10'h3FF) $display("FAIL release_early stable=%h, expected 3ff", sw_stable);
        else pass_cnt++;
        tick(1);
        chk_cnt++;
        if (sw_stable !== 10'h2FF || change_mask !== 10'h100)
            $display("FAIL release_update stable=%h mask=%h, expected 2ff/100", sw_stable, change_mask);
        else pass_cnt++;
        tick(2);
    endtask

    task automatic test_glitch();
        sw_in = 10'h020;
        tick(DEB - 1);
        sw_in = 10'h000;
        tick(10);
        chk_cnt++;
        if (sw_stable !== 10'h000) $display("FAIL glitch_reject stable=%h, expected 000", sw_stable);
        else pass_cnt++;
    endtask

    task automatic test_min_width();
        sw_in = 10'h020;
        sb.push_back('{cyc + LAT, 10'h020, 10'h020});
        tick(DEB);
        sw_in = 10'h000;
        sb.push_back('{cyc + LAT, 10'h000, 10'h020});
        tick(12);
        chk_cnt++;
        if (sw_stable !== 10'h000) $display("FAIL min_width_final stable=%h, expected 000", sw_stable);
        else pass_cnt++;
        exp_st = 10'h000;
    endtask

    task automatic test_back_to_back();
        sw_in = 10'h002;
        sb.push_back('{cyc + LAT, 10'h002, 10'h002});
        tick(1);
        sw_in = 10'h006;
        sb.push_back('{cyc + LAT, 10'h006, 10'h004});
        exp_st = 10'h006;
        tick(LAT - 1);
        chk_cnt++;
        if (sw_stable !== 10'h002 || change_mask !== 10'h002)
            $display("FAIL b2b_first stable=%h mask=%h, expected 002/002", sw_stable, change_mask);
        else pass_cnt++;
        tick(1);
        chk_cnt++;
        if (sw_stable !== 10'h006 || change_mask !== 10'h004)
            $display("FAIL b2b_second stable=%h mask=%h, expected 006/004", sw_stable, change_mask);
        else pass_cnt++;
        tick(1);
        chk_cnt++;
        if (sw_change !== 1'b0) $display("FAIL b2b_end change=%b, expected 0", sw_change);
        else pass_cnt++;
        tick(2);
    endtask

    task automatic test_mid_reset();
        sw_in = 10'h007;
        tick(3);
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (sw_stable !== '0 || sw_change !== 1'b0 || change_mask !== '0)
            $display("FAIL midrst_async stable=%h change=%b mask=%h, expected 000/0/000",
                     sw_stable, sw_change, change_mask);
        else pass_cnt++;
        exp_st = '0;
        tick(2);
        rst_n = 1'b1;
        sb.push_back('{cyc + LAT, 10'h007, 10'h007});
        exp_st = 10'h007;
        tick(LAT - 1);
        chk_cnt++;
        if (sw_stable !== 10'h000) $display("FAIL midrst_early stable=%h, expected 000", sw_stable);
        else pass_cnt++;
        tick(1);
        chk_cnt++;
        if (sw_stable !== 10'h007) $display("FAIL midrst_final stable=%h, expected 007", sw_stable);
        else pass_cnt++;
        tick(2);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        test_reset();
        test_clean_step();
        settle_to(10'h000);
        test_bounce();
        settle_to(10'h000);
        test_simultaneous();
        test_release();
        settle_to(10'h000);
        test_glitch();
        test_min_width();
        test_back_to_back();
        test_mid_reset();
        settle_to(10'h000);
        for (int w = 0; w < 20 && sb.size() > 0; w++) tick(1);
        chk_cnt++;
        if (sb.size() != 0) $display("FAIL drain pending=%0d, expected 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
